// File: rtl/logic_unit_sliced_if.sv
// logic_unit_sliced_if: operand/result handshake bundle for logic_unit_sliced.
// master = producer/consumer side, slave = the logic unit.
interface logic_unit_sliced_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/logic_unit_sliced.sv
// logic_unit_sliced: multi-cycle AND/OR/XOR/NOR, one SLICE-bit slice per clock.
// Ports: clk, rst_n (async, active low), bus (slave: in_valid/in_ready,
// in1, in2, op, out_valid/out_ready, result). With LOGIC_UNIT_ZERO_FLAG_EN
// defined an extra output zero flags an all-zero result.
module logic_unit_sliced #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  output logic zero,
`endif
  logic_unit_sliced_if.slave bus
);

  localparam int N_SLICES = WIDTH / SLICE;
  localparam int CW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_SLICES - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic [31:0]      base;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sr;
  logic [WIDTH-1:0] res_n;
  logic             last;
  logic             accept;
  logic             in_ready;
  logic             out_valid;

  assign last   = (cnt == LAST);
  assign accept = (state == IDLE) && bus.in_valid;
  assign base   = 32'(cnt) * 32'(SLICE);
  assign sa     = SLICE'(a_q >> base);
  assign sb     = SLICE'(b_q >> base);

  always_comb begin
    sr = '0;
    unique case (op_q)
      2'b00: sr = sa & sb;
      2'b01: sr = sa | sb;
      2'b10: sr = sa ^ sb;
      2'b11: sr = ~(sa | sb);
      default: sr = '0;
    endcase
  end

  // Only the current slice is replaced; higher slices keep old bits.
  assign res_n = (res_q & ~(MASK << base))
               | (WIDTH'(sr) << base);

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_n = BUSY;
      end
      BUSY: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
    end else if (accept) begin
      cnt  <= '0;
      a_q  <= bus.in1;
      b_q  <= bus.in2;
      op_q <= bus.op;
    end else if (state == BUSY) begin
      res_q <= res_n;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b1;
    end else if (state == BUSY) begin
      zero_q <= zero_q & (sr == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;

endmodule

// File: tb/tb_logic_unit_sliced.sv
// tb_logic_unit_sliced: directed checks of logic_unit_sliced.
// Main 32/4 instance plus 8/8 and 8/1 corner instances.
module tb_logic_unit_sliced;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;
  int   n8;
  int   n1;
  int   seen;

  logic_unit_sliced_if #(.WIDTH(32)) bus ();
  logic_unit_sliced_if #(.WIDTH(8))  c8 ();
  logic_unit_sliced_if #(.WIDTH(8))  c1 ();

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero;
  logic z8;
  logic z1;
`endif

  logic_unit_sliced #(.WIDTH(32), .SLICE(4)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    .zero (zero),
`endif
    .bus  (bus)
  );

  logic_unit_sliced #(.WIDTH(8), .SLICE(8)) u_w8s8 (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    .zero (z8),
`endif
    .bus  (c8)
  );

  logic_unit_sliced #(.WIDTH(8), .SLICE(1)) u_w8s1 (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    .zero (z1),
`endif
    .bus  (c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [1:0]  o);
    bus.in1 = a;
    bus.in2 = b;
    bus.op = o;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] sweep_exp [3];
    sweep_exp[0] = 32'hAFAF_5F5F;
    sweep_exp[1] = 32'hA5A5_5A5A;
    sweep_exp[2] = 32'h5050_A0A0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.op = '0;
    bus.out_ready = 1'b0;
    c8.in_valid = 1'b0;
    c8.in1 = '0;
    c8.in2 = '0;
    c8.op = '0;
    c8.out_ready = 1'b0;
    c1.in_valid = 1'b0;
    c1.in1 = '0;
    c1.in2 = '0;
    c1.op = '0;
    c1.out_ready = 1'b0;
    repeat (2) tick();

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("rst_zero", 64'(zero), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    start(32'hF0F0_1234, 32'hFF00_FFFF, 2'b00);
    chk("and_busy_ready", 64'(bus.in_ready), 64'd0);
    wait_done(n);
    chk("and_latency", 64'(n), 64'd8);
    chk("and_result", 64'(bus.result), 64'hF000_1234);
    repeat (2) tick();
    chk("and_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("and_hold_result", 64'(bus.result), 64'hF000_1234);
    handshake();
    chk("and_back_idle", 64'(bus.in_ready), 64'd1);
    chk("and_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("and_result_kept", 64'(bus.result), 64'hF000_1234);

    for (int i = 0; i < 3; i++) begin
      start(32'hAAAA_5555, 32'h0F0F_0F0F, 2'(i + 1));
      wait_done(n);
      chk("sweep_latency", 64'(n), 64'd8);
      chk("sweep_result", 64'(bus.result), 64'(sweep_exp[i]));
      handshake();
    end

    start(32'h0000_FFFF, 32'hFFFF_FFFF, 2'b00);
    wait_done(n);
    chk("bp_first", 64'(bus.result), 64'h0000_FFFF);
    bus.in1 = 32'h1234_5678;
    bus.in2 = 32'hFFFF_0000;
    bus.op = 2'b10;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_result", 64'(bus.result), 64'h0000_FFFF);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_idle_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_accepted", 64'(bus.in_ready), 64'd0);
    wait_done(n);
    chk("bp_latency", 64'(n), 64'd8);
    chk("bp_result2", 64'(bus.result), 64'hEDCB_5678);
    handshake();

    start(32'h0000_00F0, 32'h0000_000F, 2'b00);
    bus.in1 = 32'hFFFF_FFFF;
    bus.in2 = 32'hFFFF_FFFF;
    bus.op = 2'b01;
    wait_done(n);
    chk("chg_latency", 64'(n), 64'd8);
    chk("chg_result", 64'(bus.result), 64'd0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("zero_and", 64'(zero), 64'd1);
`endif
    handshake();
    start(32'h0000_00F0, 32'h0000_000F, 2'b01);
    wait_done(n);
    chk("or_result", 64'(bus.result), 64'h0000_00FF);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("zero_or", 64'(zero), 64'd0);
`endif
    handshake();

    start(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b01);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_result", 64'(bus.result), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk("post_rst_quiet", 64'(seen), 64'd0);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    c8.in1 = 8'h3C;
    c8.in2 = 8'h0F;
    c8.op = 2'b10;
    c1.in1 = 8'h3C;
    c1.in2 = 8'h0F;
    c1.op = 2'b10;
    c8.in_valid = 1'b1;
    c1.in_valid = 1'b1;
    tick();
    c8.in_valid = 1'b0;
    c1.in_valid = 1'b0;
    n8 = 0;
    n1 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (c8.out_valid === 1'b1 && n8 == 0) n8 = k;
      if (c1.out_valid === 1'b1 && n1 == 0) n1 = k;
    end
    chk("w8s8_latency", 64'(n8), 64'd1);
    chk("w8s1_latency", 64'(n1), 64'd8);
    chk("w8s8_result", 64'(c8.result), 64'h33);
    chk("w8s1_result", 64'(c1.result), 64'h33);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("w8s1_zero", 64'(z1), 64'd0);
    chk("w8s8_zero", 64'(z8), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_sliced.md
Name: logic_unit_sliced

Overview:
- Parametrised, multi-cycle bitwise logic unit for the MIPS datapath. Generalises the fixed 32-bit AND to any WIDTH and four ops: AND, OR, XOR, NOR.
- Processes one SLICE-bit slice per clock, LSB slice first, so area scales with SLICE rather than WIDTH.
- Uses a valid/ready handshake on both input and output, so the ALU controller can stall on it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 <= SLICE <= WIDTH.
- N_SLICES is derived as WIDTH/SLICE and is not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit can accept operands.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- op  in  2  00=AND, 01=OR, 10=XOR, 11=NOR.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  bitwise result.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, slice counter=0, result=0, out_valid=0, in_ready=1.
  - Operand/op capture registers are cleared to 0.
  - Reset mid-operation abandons the operation; nothing is emitted after release.
- Clocking and reset: one clock only; reset is asynchronous and active-low.
- States:
  - IDLE: in_ready=1, out_valid=0. When in_valid is high at a rising edge, latch in1, in2 and op into internal registers, clear the counter, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each edge computes slice[cnt] = op(in1_q[cnt*SLICE +: SLICE], in2_q[...]) into result[cnt*SLICE +: SLICE], then increments cnt. On the edge with cnt == N_SLICES-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. result is held stable. When out_ready is high at an edge, go to IDLE.
- Latency:
  - Accept at edge k; out_valid rises after edge k+N_SLICES.
  - WIDTH=32, SLICE=4 gives 8 cycles.
  - SLICE=WIDTH gives 1 cycle.
- Throughput: one op per N_SLICES+2 cycles minimum (accept, N slices, handshake). No back-to-back accept in DONE.
- Input changes: in1/in2/op changes after acceptance have no effect on the running operation.
- Result visibility:
  - result bits above the current slice still hold the previous operation's value during BUSY.
  - result is only meaningful while out_valid=1.
  - After the DONE→IDLE handshake, result keeps its last value until the next accept overwrites it slice by slice.
- Counter: width is max(1, clog2(N_SLICES)); it never exceeds N_SLICES-1 and wraps to 0 on each accept.
- in_valid while not in IDLE is ignored; the source must hold it until in_ready.
- out_ready while out_valid=0 is ignored.
- NOR is ~(a|b) per bit.
- No arithmetic and no carries between slices; slices are fully independent.

Optional Feature:
- Macro LOGIC_UNIT_ZERO_FLAG_EN.
- When defined:
  - Adds output port zero (1 bit).
  - zero is accumulated across slices: cleared to 1 on accept, ANDed with (slice==0) each BUSY cycle.
  - zero is valid and stable with out_valid, and resets to 0.
  - Used for BEQ/BNE on logic results.
- When undefined: no zero port and no extra registers. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-BUSY (3 cycles after accept) → out_valid=0, in_ready=1, result=0 asynchronously; no out_valid after release.
- AND, defaults: in1=0xF0F0_1234, in2=0xFF00_FFFF, op=00 → out_valid exactly 8 cycles after accept, result=0xF000_1234, held until out_ready.
- OR/XOR/NOR sweep: in1=0xAAAA_5555, in2=0x0F0F_0F0F:
  - op=01 → 0xAFAF_5F5F
  - op=10 → 0xA5A5_5A5A
  - op=11 → 0x5050_A0A0
- Backpressure: keep out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0; new in_valid ignored; accept happens 1 cycle after the DONE→IDLE handshake.
- Parameter corners:
  - WIDTH=8, SLICE=8: in1=0x3C, in2=0x0F, op=10 → result=0x33 after 1 cycle.
  - WIDTH=8, SLICE=1: same stimulus → 8 cycles.
- Zero flag (LOGIC_UNIT_ZERO_FLAG_EN defined):
  - in1=0x0000_00F0, in2=0x0000_000F, op=00 → zero=1.
  - op=01 → zero=0.
  - Change operands during BUSY → result and zero unaffected.
